lease_sampler_drain_ctrl: RTL and testbench
===========================================

# lease_sampler_drain_ctrl

Host-facing sequencer for the lease sampler buffer. It starts and stops sampling, watches the buffer-full flag, and drives the sampler's comm port to read entries out one at a time. Each entry is packed into a five-word record stream with a valid/ready handshake, and the buffer is cleared afterwards. It sits between the host command link and the sampler's comm_i port and replaces hand-sequenced comm writes.

## Interface
Parameters:
- P_ADDR_W, 13, sampler buffer address width
- P_READ_LAT, 2, cycles from read address out to sampler data valid
- P_TABLE_N, 128, sampler table entries, sets the table-dump wait length

Ports:
- clock_i  in  1  single clock
- reset_i  in  1  asynchronous, active-high reset
- host_cmd_i  in  2  command: 01 start, 10 stop+flush, 11 abort, 00 no-op
- host_cmd_valid_i  in  1  command valid
- host_cmd_ready_o  out  1  command accepted this cycle when valid&ready
- smp_comm_o  out  32  [24] run, [23] clear pulse, [22] table-dump pulse, [16:4] read address, all other bits 0
- smp_full_i  in  1  sampler buffer full
- smp_used_i  in  32  sampler entries used
- smp_interval_i, smp_address_i, smp_target_i  in  32 each  sampler read data
- smp_trace_i  in  64  sampler trace read data
- rec_data_o  out  32  record word
- rec_valid_o  out  1  record word valid
- rec_ready_i  in  1  downstream accepts word
- rec_last_o  out  1  marks the final word of a record
- busy_o  out  1  high in any state except IDLE
- state_o  out  4  current state encoding
- drain_count_o  out  32  total records emitted since reset

## Operation
States and transitions:
- IDLE: run=0. Start goes to RUN. Stop or abort is accepted and ignored.
- RUN: run=1. smp_full_i goes to DRAIN_ADDR with resume=1. Stop goes to DUMP. Abort goes to CLEAR with resume=0.
- DUMP: run=0 and table-dump=1 for exactly one cycle. Then go to DUMP_WAIT.
- DUMP_WAIT: wait P_TABLE_N+2 cycles, then go to DRAIN_ADDR with resume=0.

Drain sequence:
- On entry to the drain, latch n_entries = smp_used_i[P_ADDR_W-1:0] and set idx=0.
- During the drain, run keeps its previous value, so the core stays stalled and comm owns the buffer address.
- DRAIN_ADDR: drive read address=idx. Go to DRAIN_WAIT.
- DRAIN_WAIT: after P_READ_LAT cycles, capture all five data inputs into holding registers.
  - If the captured interval is 0 (unfilled slot), emit nothing.
  - Otherwise go to SEND.
- SEND: emit the record words in this order:
  - word 0: address
  - word 1: interval
  - word 2: trace[31:0]
  - word 3: trace[63:32]
  - word 4: target, with rec_last_o=1
- After each entry, idx increments. When idx==n_entries, go to CLEAR; otherwise go to DRAIN_ADDR.
- CLEAR: clear=1 for one cycle. Then go to RUN if resume=1, else IDLE.

Command and counter rules:
- host_cmd_ready_o=1 in IDLE and RUN.
- In all other states host_cmd_ready_o is high only when host_cmd_i==11 (abort).
- Abort in DRAIN_*/SEND/DUMP_*: rec_valid_o drops the next cycle, the partial record is discarded, and the block goes to CLEAR with resume=0.
- drain_count_o increments by exactly 1 on each accepted word 4. It wraps at 2^32.

## Timing
- Reset values: smp_comm_o=0, rec_valid_o=0, rec_last_o=0, rec_data_o=0, busy_o=0, state=IDLE, drain_count_o=0, host_cmd_ready_o=1.
- All outputs are registered. A command is accepted in cycle t and the state changes at t+1.
- A smp_full_i rising in RUN produces the first read address 1 cycle later.
- The first record word is valid 1+P_READ_LAT+1 cycles after its address is driven.
- Handshake:
  - rec_data_o and rec_last_o stay stable while valid&!ready.
  - A new word may follow on the cycle after acceptance, so full throughput is 1 word per cycle.
- Simultaneous smp_full_i and stop in RUN: the stop wins. The block goes to DUMP, and the drain that follows empties both the buffer and the table.
- n_entries==0: go straight to CLEAR.
- The read address wraps only through idx < n_entries.
- Reset mid-drain: everything returns to the reset values immediately, no clear pulse is issued, and the sampler's own reset governs its contents.

## Structure
- Shared package: state encoding, command codes (CMD_START, CMD_STOP, CMD_ABORT), comm bit positions (COMM_RUN=24, COMM_CLEAR=23, COMM_DUMP=22, COMM_ADDR_LSB=4), record length constant 5.
- Sub-module: lease_record_serializer holds the five-word buffer, the word index and the valid/ready output. The FSM remains in the top module.

## Test plan
- Start, then force smp_full_i=1 with smp_used_i=3 and rec_ready_i=1:
  - read addresses 0,1,2 are driven, 15 words are emitted with rec_last_o on words 4/9/14;
  - one clear pulse follows, then run=1 again and drain_count_o=3.
- Stop in RUN: a single-cycle bit22 pulse, then exactly P_TABLE_N+2 wait cycles, then the drain, the clear, and IDLE with busy_o=0.
- Backpressure: rec_ready_i toggling 1-in-3 during SEND holds the data stable; each word is accepted exactly once; entry order is preserved.
- An entry with interval=0 at idx 1 of 3 emits only 10 words, and drain_count_o increases by 2.
- Abort during word 2 of SEND: rec_valid_o is low next cycle, a clear pulse follows, the block ends in IDLE, and drain_count_o is unchanged.
- Assert reset_i asynchronously mid-DRAIN_WAIT: smp_comm_o=0 and all outputs return to reset values in the same cycle.

Source files
------------

// File: rtl/lease_sampler_drain_ctrl_pkg.sv
`default_nettype none
// lease_sampler_drain_ctrl_pkg -- shared encodings for the lease sampler drain controller.
// Revision 1.0
package lease_sampler_drain_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_IDLE       = 4'd0,
    ST_RUN        = 4'd1,
    ST_DUMP       = 4'd2,
    ST_DUMP_WAIT  = 4'd3,
    ST_DRAIN_ADDR = 4'd4,
    ST_DRAIN_WAIT = 4'd5,
    ST_SEND       = 4'd6,
    ST_CLEAR      = 4'd7
  } state_e;

  localparam logic [1:0] CMD_NOP   = 2'b00;
  localparam logic [1:0] CMD_START = 2'b01;
  localparam logic [1:0] CMD_STOP  = 2'b10;
  localparam logic [1:0] CMD_ABORT = 2'b11;

  localparam int COMM_RUN      = 24;
  localparam int COMM_CLEAR    = 23;
  localparam int COMM_DUMP     = 22;
  localparam int COMM_ADDR_LSB = 4;

  localparam int REC_LEN   = 5;
  localparam int REC_IDX_W = 3;

  function automatic logic is_drain(input state_e s);
    return (s == ST_DRAIN_ADDR) || (s == ST_DRAIN_WAIT) || (s == ST_SEND);
  endfunction

endpackage
`default_nettype wire

// File: rtl/lease_sampler_drain_ctrl_serializer.sv
`default_nettype none
// lease_record_serializer -- five-word record buffer streamed out over valid/ready.
// Revision 1.0
module lease_record_serializer
  import lease_sampler_drain_ctrl_pkg::*;
(
  input  logic                     clock_i,
  input  logic                     reset_i,
  input  logic                     load_i,
  input  logic                     flush_i,
  input  logic [REC_LEN-1:0][31:0] words_i,
  input  logic                     rec_ready_i,
  output logic [31:0]              rec_data_o,
  output logic                     rec_valid_o,
  output logic                     rec_last_o
);

  logic [REC_LEN-1:0][31:0] buf_q, buf_d;
  logic [REC_IDX_W-1:0]     idx_q, idx_d, idx_nxt;
  logic [31:0]              data_q, data_d;
  logic                     valid_q, valid_d;
  logic                     last_q, last_d;

  always_comb begin
    buf_d   = buf_q;
    idx_d   = idx_q;
    data_d  = data_q;
    valid_d = valid_q;
    last_d  = last_q;
    idx_nxt = idx_q + 1'b1;
    if (flush_i) begin
      valid_d = 1'b0;
      last_d  = 1'b0;
    end else if (load_i) begin
      buf_d   = words_i;
      idx_d   = '0;
      data_d  = words_i[0];
      valid_d = 1'b1;
      last_d  = 1'b0;
    end else if (valid_q && rec_ready_i) begin
      if (last_q) begin
        valid_d = 1'b0;
        last_d  = 1'b0;
      end else begin
        // Data is only advanced on acceptance, so it holds steady under backpressure.
        idx_d  = idx_nxt;
        data_d = buf_q[idx_nxt];
        last_d = (idx_nxt == REC_IDX_W'(REC_LEN - 1));
      end
    end
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      buf_q   <= '0;
      idx_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      buf_q   <= buf_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      last_q  <= last_d;
    end
  end

  assign rec_data_o  = data_q;
  assign rec_valid_o = valid_q;
  assign rec_last_o  = last_q;

endmodule
`default_nettype wire

// File: rtl/lease_sampler_drain_ctrl.sv
`default_nettype none
// lease_sampler_drain_ctrl -- host-driven start/stop/drain sequencer for the lease sampler.
// Revision 1.0
module lease_sampler_drain_ctrl
  import lease_sampler_drain_ctrl_pkg::*;
#(
  parameter int P_ADDR_W   = 13,
  parameter int P_READ_LAT = 2,
  parameter int P_TABLE_N  = 128
) (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic [1:0]  host_cmd_i,
  input  logic        host_cmd_valid_i,
  output logic        host_cmd_ready_o,
  output logic [31:0] smp_comm_o,
  input  logic        smp_full_i,
  input  logic [31:0] smp_used_i,
  input  logic [31:0] smp_interval_i,
  input  logic [31:0] smp_address_i,
  input  logic [31:0] smp_target_i,
  input  logic [63:0] smp_trace_i,
  output logic [31:0] rec_data_o,
  output logic        rec_valid_o,
  input  logic        rec_ready_i,
  output logic        rec_last_o,
  output logic        busy_o,
  output logic [3:0]  state_o,
  output logic [31:0] drain_count_o
);

  localparam logic [31:0] C_DUMP_WAIT_END = 32'(P_TABLE_N + 1);
  localparam logic [31:0] C_READ_WAIT_END = 32'(P_READ_LAT);

  state_e                   state_q, state_d;
  logic [P_ADDR_W-1:0]      idx_q, idx_d, n_q, n_d, idx_inc, used_entries;
  logic [31:0]              cnt_q, cnt_d, comm_q, comm_d, count_q, count_d;
  logic                     resume_q, resume_d, busy_q, busy_d, run_d;
  logic                     cmd_fire, cmd_start, cmd_stop, cmd_abort;
  logic                     start_drain, advance, ser_load, ser_flush, rec_done;
  logic [REC_LEN-1:0][31:0] rec_words;
  logic                     unused_used;

  // Outside IDLE/RUN only an abort may be taken, so ready follows the command code.
  assign host_cmd_ready_o = (state_q == ST_IDLE) || (state_q == ST_RUN) ||
                            (host_cmd_i == CMD_ABORT);
  assign cmd_fire     = host_cmd_valid_i && host_cmd_ready_o;
  assign cmd_start    = cmd_fire && (host_cmd_i == CMD_START);
  assign cmd_stop     = cmd_fire && (host_cmd_i == CMD_STOP);
  assign cmd_abort    = cmd_fire && (host_cmd_i == CMD_ABORT);
  assign rec_done     = rec_valid_o && rec_ready_i && rec_last_o;
  assign idx_inc      = idx_q + 1'b1;
  assign used_entries = smp_used_i[P_ADDR_W-1:0];
  assign unused_used  = &{1'b0, smp_used_i};
  assign rec_words    = {smp_target_i, smp_trace_i[63:32], smp_trace_i[31:0],
                         smp_interval_i, smp_address_i};

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    n_d         = n_q;
    cnt_d       = cnt_q;
    resume_d    = resume_q;
    start_drain = 1'b0;
    advance     = 1'b0;
    ser_load    = 1'b0;
    ser_flush   = 1'b0;
    case (state_q)
      ST_IDLE: if (cmd_start) state_d = ST_RUN;
      ST_RUN: begin
        if (cmd_stop) begin
          state_d = ST_DUMP;
        end else if (smp_full_i) begin
          start_drain = 1'b1;
          resume_d    = 1'b1;
        end
      end
      ST_DUMP: begin
        state_d = ST_DUMP_WAIT;
        cnt_d   = '0;
      end
      ST_DUMP_WAIT: begin
        if (cnt_q == C_DUMP_WAIT_END) begin
          start_drain = 1'b1;
          resume_d    = 1'b0;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      ST_DRAIN_ADDR: begin
        state_d = ST_DRAIN_WAIT;
        cnt_d   = '0;
      end
      ST_DRAIN_WAIT: begin
        // One cycle beyond the read latency so the sampler data has settled when captured.
        if (cnt_q == C_READ_WAIT_END) begin
          if (smp_interval_i != 32'd0) begin
            ser_load = 1'b1;
            state_d  = ST_SEND;
          end else begin
            advance = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      ST_SEND:  if (rec_done) advance = 1'b1;
      ST_CLEAR: state_d = (resume_q && !cmd_abort) ? ST_RUN : ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    if (start_drain) begin
      n_d     = used_entries;
      idx_d   = '0;
      state_d = (used_entries == '0) ? ST_CLEAR : ST_DRAIN_ADDR;
    end
    if (advance) begin
      idx_d   = idx_inc;
      state_d = (idx_inc == n_q) ? ST_CLEAR : ST_DRAIN_ADDR;
    end
    if (cmd_abort && (state_q != ST_IDLE) && (state_q != ST_CLEAR)) begin
      state_d   = ST_CLEAR;
      resume_d  = 1'b0;
      ser_load  = 1'b0;
      ser_flush = 1'b1;
    end
  end

  // Comm word is built from the next state so it lines up with state_o.
  always_comb begin
    run_d = comm_q[COMM_RUN];
    case (state_d)
      ST_RUN:                        run_d = 1'b1;
      ST_IDLE, ST_DUMP, ST_DUMP_WAIT: run_d = 1'b0;
      ST_CLEAR:                      run_d = resume_d;
      default:                       run_d = comm_q[COMM_RUN];
    endcase
    comm_d             = '0;
    comm_d[COMM_RUN]   = run_d;
    comm_d[COMM_CLEAR] = (state_d == ST_CLEAR);
    comm_d[COMM_DUMP]  = (state_d == ST_DUMP);
    if (is_drain(state_d)) comm_d[COMM_ADDR_LSB +: P_ADDR_W] = idx_d;
    busy_d  = (state_d != ST_IDLE);
    count_d = rec_done ? count_q + 32'd1 : count_q;
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      n_q      <= '0;
      cnt_q    <= '0;
      resume_q <= 1'b0;
      comm_q   <= '0;
      busy_q   <= 1'b0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      n_q      <= n_d;
      cnt_q    <= cnt_d;
      resume_q <= resume_d;
      comm_q   <= comm_d;
      busy_q   <= busy_d;
      count_q  <= count_d;
    end
  end

  lease_record_serializer u_ser (
    .clock_i     (clock_i),
    .reset_i     (reset_i),
    .load_i      (ser_load),
    .flush_i     (ser_flush),
    .words_i     (rec_words),
    .rec_ready_i (rec_ready_i),
    .rec_data_o  (rec_data_o),
    .rec_valid_o (rec_valid_o),
    .rec_last_o  (rec_last_o)
  );

  assign smp_comm_o    = comm_q;
  assign busy_o        = busy_q;
  assign state_o       = state_q;
  assign drain_count_o = count_q;

endmodule
`default_nettype wire

// File: tb/tb_lease_sampler_drain_ctrl.sv
`default_nettype none
// tb_lease_sampler_drain_ctrl -- directed vector bench for the lease sampler drain controller.
// Revision 1.0
module tb_lease_sampler_drain_ctrl;

  localparam int TBL = 8;
  localparam logic [1:0] NOP = 2'b00, START = 2'b01, STOP = 2'b10, ABORT = 2'b11;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  host_cmd = NOP;
  logic        cmd_vld = 1'b0;
  logic        cmd_rdy;
  logic [31:0] comm;
  logic        full = 1'b0;
  logic [31:0] used = 32'd0;
  logic [31:0] smp_interval, smp_address, smp_target;
  logic [63:0] smp_trace;
  logic [31:0] rec_data;
  logic        rec_valid, rec_last, busy;
  logic        ready = 1'b1;
  logic [3:0]  state;
  logic [31:0] dcount;

  logic [31:0] intv_m [8];
  logic [31:0] addr_m [8];
  logic [31:0] tgt_m  [8];
  logic [63:0] tr_m   [8];
  logic [12:0] a1 = '0, a2 = '0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lease_sampler_drain_ctrl #(.P_ADDR_W(13), .P_READ_LAT(2), .P_TABLE_N(TBL)) dut (
    .clock_i(clk), .reset_i(rst), .host_cmd_i(host_cmd), .host_cmd_valid_i(cmd_vld),
    .host_cmd_ready_o(cmd_rdy), .smp_comm_o(comm), .smp_full_i(full), .smp_used_i(used),
    .smp_interval_i(smp_interval), .smp_address_i(smp_address), .smp_target_i(smp_target),
    .smp_trace_i(smp_trace), .rec_data_o(rec_data), .rec_valid_o(rec_valid),
    .rec_ready_i(ready), .rec_last_o(rec_last), .busy_o(busy), .state_o(state),
    .drain_count_o(dcount)
  );

  // Sampler read port: data follows the comm address after two cycles.
  always @(posedge clk) begin
    a1 <= comm[16:4];
    a2 <= a1;
  end
  assign smp_interval = intv_m[a2[2:0]];
  assign smp_address  = addr_m[a2[2:0]];
  assign smp_target   = tgt_m[a2[2:0]];
  assign smp_trace    = tr_m[a2[2:0]];

  // Monitor (sole writer of these variables).
  logic [32:0] got_q [$];
  logic [12:0] addr_q [$];
  int          acyc_q [$];
  int          vrise_q [$];
  int          cyc = 0, clr_cnt = 0, dump_cnt = 0, dwait_cnt = 0, stab_chk = 0, stab_err = 0;
  logic        prev_valid = 1'b0, hold_prev = 1'b0;
  logic [32:0] held = '0;

  always @(negedge clk) begin
    cyc++;
    if (rec_valid && ready) got_q.push_back({rec_last, rec_data});
    if (rec_valid && !prev_valid) vrise_q.push_back(cyc);
    prev_valid = rec_valid;
    if (state == 4'd4) begin
      addr_q.push_back(comm[16:4]);
      acyc_q.push_back(cyc);
    end
    if (comm[23]) clr_cnt++;
    if (comm[22]) dump_cnt++;
    if (state == 4'd3) dwait_cnt++;
    if (hold_prev && rec_valid) begin
      stab_chk++;
      if ({rec_last, rec_data} !== held) stab_err++;
    end
    hold_prev = rec_valid && !ready;
    held      = {rec_last, rec_data};
  end

  typedef struct {
    logic [1:0]  cmd;
    logic        vld;
    logic        full;
    logic [31:0] used;
    logic [3:0]  st;
    logic        busy;
    logic        rdy;
    logic [31:0] comm;
  } vec_t;

  vec_t        vec [13];
  logic [32:0] exp_q [$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic wait_state(input logic [3:0] s, input int budget, input string name);
    int n = 0;
    while (state !== s && n < budget) begin
      tick();
      n++;
    end
    chk(name, 64'(state), 64'(s));
  endtask

  task automatic expect_entry(input int i);
    exp_q.push_back({1'b0, addr_m[i]});
    exp_q.push_back({1'b0, intv_m[i]});
    exp_q.push_back({1'b0, tr_m[i][31:0]});
    exp_q.push_back({1'b0, tr_m[i][63:32]});
    exp_q.push_back({1'b1, tgt_m[i]});
  endtask

  task automatic check_words(input string tag, input int base);
    chk({tag, "_nwords"}, 64'(got_q.size() - base), 64'(exp_q.size()));
    for (int k = 0; k < exp_q.size() && base + k < got_q.size(); k++)
      chk($sformatf("%s_w%0d", tag, k), 64'(got_q[base + k]), 64'(exp_q[k]));
    exp_q.delete();
  endtask

  initial begin
    int gb, ab, vb, cb, db, wb;
    for (int i = 0; i < 8; i++) begin
      intv_m[i] = 32'h10 + i;
      addr_m[i] = 32'hA000_0000 + i;
      tgt_m[i]  = 32'hD000_0000 + i;
      tr_m[i]   = {32'hB000_0000 + 32'(i), 32'hC000_0000 + 32'(i)};
    end
    //          cmd    vld   full  used          st    busy  rdy   comm
    vec[0]  = '{NOP,   1'b0, 1'b0, 32'd0,       4'd0, 1'b0, 1'b1, 32'h0000_0000};
    vec[1]  = '{STOP,  1'b1, 1'b0, 32'd0,       4'd0, 1'b0, 1'b1, 32'h0000_0000};
    vec[2]  = '{ABORT, 1'b1, 1'b0, 32'd0,       4'd0, 1'b0, 1'b1, 32'h0000_0000};
    vec[3]  = '{START, 1'b1, 1'b0, 32'd0,       4'd1, 1'b1, 1'b1, 32'h0100_0000};
    vec[4]  = '{START, 1'b1, 1'b0, 32'd0,       4'd1, 1'b1, 1'b1, 32'h0100_0000};
    vec[5]  = '{STOP,  1'b0, 1'b0, 32'd0,       4'd1, 1'b1, 1'b1, 32'h0100_0000};
    vec[6]  = '{ABORT, 1'b1, 1'b0, 32'd0,       4'd7, 1'b1, 1'b0, 32'h0080_0000};
    vec[7]  = '{NOP,   1'b0, 1'b0, 32'd0,       4'd0, 1'b0, 1'b1, 32'h0000_0000};
    vec[8]  = '{START, 1'b1, 1'b0, 32'd0,       4'd1, 1'b1, 1'b1, 32'h0100_0000};
    vec[9]  = '{NOP,   1'b0, 1'b1, 32'd0,       4'd7, 1'b1, 1'b0, 32'h0180_0000};
    vec[10] = '{NOP,   1'b0, 1'b0, 32'd0,       4'd1, 1'b1, 1'b1, 32'h0100_0000};
    vec[11] = '{NOP,   1'b0, 1'b1, 32'h2000,    4'd7, 1'b1, 1'b0, 32'h0180_0000};
    vec[12] = '{NOP,   1'b0, 1'b0, 32'd0,       4'd1, 1'b1, 1'b1, 32'h0100_0000};

    // Reset values
    tick();
    tick();
    chk("rst_state", 64'(state), 0);
    chk("rst_comm", 64'(comm), 0);
    chk("rst_outs", 64'({rec_valid, rec_last, busy, cmd_rdy}), 64'(4'b0001));
    chk("rst_data", 64'(rec_data), 0);
    chk("rst_count", 64'(dcount), 0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 13; i++) begin
      host_cmd = vec[i].cmd;
      cmd_vld  = vec[i].vld;
      full     = vec[i].full;
      used     = vec[i].used;
      tick();
      host_cmd = NOP;
      cmd_vld  = 1'b0;
      full     = 1'b0;
      #1;
      chk($sformatf("vec%0d_state", i), 64'(state), 64'(vec[i].st));
      chk($sformatf("vec%0d_busy", i), 64'(busy), 64'(vec[i].busy));
      chk($sformatf("vec%0d_ready", i), 64'(cmd_rdy), 64'(vec[i].rdy));
      chk($sformatf("vec%0d_comm", i), 64'(comm), 64'(vec[i].comm));
    end

    // Full-triggered drain of three entries, no backpressure
    gb = got_q.size(); ab = addr_q.size(); vb = vrise_q.size(); cb = clr_cnt;
    used = 32'd3; ready = 1'b1; full = 1'b1;
    tick();
    full = 1'b0;
    chk("full_addr_state", 64'(state), 4);
    chk("full_addr_comm", 64'(comm), 64'(32'h0100_0000));
    wait_state(4'd1, 200, "drainA_done");
    for (int i = 0; i < 3; i++) expect_entry(i);
    check_words("drainA", gb);
    chk("drainA_naddr", 64'(addr_q.size() - ab), 3);
    for (int i = 0; i < 3 && ab + i < addr_q.size(); i++)
      chk($sformatf("drainA_addr%0d", i), 64'(addr_q[ab + i]), 64'(i));
    if (vrise_q.size() > vb && acyc_q.size() > ab)
      chk("drainA_latency", 64'(vrise_q[vb] - acyc_q[ab]), 4);
    else
      chk("drainA_latency_seen", 0, 1);
    chk("drainA_clear", 64'(clr_cnt - cb), 1);
    chk("drainA_comm", 64'(comm), 64'(32'h0100_0000));
    chk("drainA_count", 64'(dcount), 3);

    // Backpressure: ready high one cycle in three
    gb = got_q.size();
    used = 32'd3; ready = 1'b0; full = 1'b1;
    tick();
    full = 1'b0;
    for (int c = 0; c < 400 && state !== 4'd1; c++) begin
      ready = (c % 3 == 2);
      tick();
    end
    ready = 1'b1;
    chk("bp_done", 64'(state), 1);
    for (int i = 0; i < 3; i++) expect_entry(i);
    check_words("bp", gb);
    chk("bp_stall_seen", 64'(stab_chk > 0), 1);
    chk("bp_hold_stable", 64'(stab_err), 0);
    chk("bp_count", 64'(dcount), 6);

    // Unfilled slot at idx 1
    intv_m[1] = 32'd0;
    gb = got_q.size();
    used = 32'd3; full = 1'b1;
    tick();
    full = 1'b0;
    wait_state(4'd1, 200, "skip_done");
    expect_entry(0);
    expect_entry(2);
    check_words("skip", gb);
    chk("skip_count", 64'(dcount), 8);
    intv_m[1] = 32'h11;

    // Abort while word 2 is on the output
    ready = 1'b0; used = 32'd3; full = 1'b1;
    tick();
    full = 1'b0;
    wait_state(4'd6, 50, "abort_reach_send");
    gb = got_q.size(); cb = clr_cnt;
    ready = 1'b1;
    tick();
    tick();
    ready = 1'b0;
    chk("abort_word2", 64'(rec_data), 64'(tr_m[0][31:0]));
    host_cmd = STOP; cmd_vld = 1'b1;
    #1;
    chk("send_stop_ready", 64'(cmd_rdy), 0);
    host_cmd = ABORT;
    #1;
    chk("send_abort_ready", 64'(cmd_rdy), 1);
    tick();
    host_cmd = NOP; cmd_vld = 1'b0;
    chk("abort_valid_drop", 64'(rec_valid), 0);
    chk("abort_clear_state", 64'(state), 7);
    chk("abort_clear_comm", 64'(comm), 64'(32'h0080_0000));
    tick();
    chk("abort_idle", 64'({state, busy}), 0);
    chk("abort_clear_once", 64'(clr_cnt - cb), 1);
    chk("abort_words", 64'(got_q.size() - gb), 2);
    chk("abort_count", 64'(dcount), 8);
    ready = 1'b1;

    // Stop: dump pulse, table wait, drain, clear, back to IDLE
    host_cmd = START; cmd_vld = 1'b1;
    tick();
    host_cmd = NOP; cmd_vld = 1'b0;
    gb = got_q.size(); cb = clr_cnt; db = dump_cnt; wb = dwait_cnt;
    used = 32'd2;
    host_cmd = STOP; cmd_vld = 1'b1; full = 1'b1;
    tick();
    host_cmd = NOP; cmd_vld = 1'b0; full = 1'b0;
    chk("stop_dump_state", 64'(state), 2);
    chk("stop_dump_comm", 64'(comm), 64'(32'h0040_0000));
    wait_state(4'd0, TBL + 200, "stop_done");
    chk("stop_dump_pulses", 64'(dump_cnt - db), 1);
    chk("stop_wait_cycles", 64'(dwait_cnt - wb), 64'(TBL + 2));
    expect_entry(0);
    expect_entry(1);
    check_words("stop", gb);
    chk("stop_clear", 64'(clr_cnt - cb), 1);
    chk("stop_busy", 64'(busy), 0);
    chk("stop_comm", 64'(comm), 0);
    chk("stop_count", 64'(dcount), 10);

    // Asynchronous reset in the middle of DRAIN_WAIT
    host_cmd = START; cmd_vld = 1'b1;
    tick();
    host_cmd = NOP; cmd_vld = 1'b0;
    used = 32'd3; full = 1'b1;
    tick();
    full = 1'b0;
    wait_state(4'd5, 20, "rst_reach_wait");
    #2;
    rst = 1'b1;
    #1;
    chk("arst_comm", 64'(comm), 0);
    chk("arst_state", 64'(state), 0);
    chk("arst_outs", 64'({rec_valid, rec_last, busy, cmd_rdy}), 64'(4'b0001));
    chk("arst_data", 64'(rec_data), 0);
    chk("arst_count", 64'(dcount), 0);
    tick();
    rst = 1'b0;
    tick();
    chk("arst_after", 64'({state, comm}), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
